// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in/serial-out shifter with a one-word holding buffer and valid/ready input
module piso_serializer #(
  parameter int   WIDTH      = 8,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic             in_msb_first,
  output logic             in_ready,
  input  logic             shift_en,
  output logic             serial_out,
  output logic             out_valid,
  output logic             out_first,
  output logic             out_last,
  output logic             busy
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t state_q, state_d;
  logic [WIDTH-1:0] hold_q, hold_d, shreg_q, shreg_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic hold_valid_q, hold_valid_d, hold_msb_q, hold_msb_d, msb_q, msb_d;
  logic accept, shifting, done, load, step;
  assign in_ready = !hold_valid_q && !reset;
  always_comb begin
    accept = in_valid && in_ready;
    shifting = (state_q == SHIFT) && shift_en;
    done = shifting && (cnt_q == '0);
    step = shifting && !done;
    // the last bit's strobe doubles as the load edge of a held word, so streams stay gapless
    load = hold_valid_q && ((state_q == IDLE) || done);
    hold_d = accept ? in_data : hold_q;
    hold_msb_d = accept ? in_msb_first : hold_msb_q;
    hold_valid_d = accept || (hold_valid_q && !load);
    state_d = load ? SHIFT : done ? IDLE : state_q;
    msb_d = load ? hold_msb_q : msb_q;
    cnt_d = load ? CW'(WIDTH - 1) : step ? cnt_q - CW'(1) : cnt_q;
    shreg_d = load ? hold_q :
              !step ? shreg_q :
              msb_q ? {shreg_q[WIDTH-2:0], IDLE_LEVEL} : {IDLE_LEVEL, shreg_q[WIDTH-1:1]};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hold_q <= '0;
      hold_msb_q <= 1'b0;
      hold_valid_q <= 1'b0;
      shreg_q <= '0;
      msb_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      hold_q <= hold_d;
      hold_msb_q <= hold_msb_d;
      hold_valid_q <= hold_valid_d;
      shreg_q <= shreg_d;
      msb_q <= msb_d;
      cnt_q <= cnt_d;
    end
  end
  assign out_valid = (state_q == SHIFT);
  assign serial_out = out_valid ? (msb_q ? shreg_q[WIDTH-1] : shreg_q[0]) : IDLE_LEVEL;
  assign out_first = out_valid && (cnt_q == CW'(WIDTH - 1));
  assign out_last = out_valid && (cnt_q == '0);
  assign busy = out_valid || hold_valid_q;
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: directed vectors, corner sequences and a randomized word-queue reference model
module tb_piso_serializer;
  localparam int W = 8;
  localparam logic IDLE = 1'b1;
  logic clk = 1'b0;
  logic reset, in_valid, in_msb_first, shift_en;
  logic [W-1:0] in_data;
  logic in_ready, serial_out, out_valid, out_first, out_last, busy;
  int checks = 0;
  int failures = 0;

  piso_serializer #(.WIDTH(W), .IDLE_LEVEL(IDLE)) dut (
    .clk(clk), .reset(reset), .in_data(in_data), .in_valid(in_valid),
    .in_msb_first(in_msb_first), .in_ready(in_ready), .shift_en(shift_en),
    .serial_out(serial_out), .out_valid(out_valid), .out_first(out_first),
    .out_last(out_last), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] d;
    logic       m;
    int         per;
    logic [7:0] seq;
  } vec_t;

  typedef struct {
    logic [7:0] d;
    logic       m;
  } word_t;

  vec_t vecs[5];
  word_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [7:0] d, input logic m, input int per, input logic [7:0] seq);
    in_valid = 1'b1;
    in_data = d;
    in_msb_first = m;
    shift_en = 1'b1;
    chk("rdy_pre", in_ready, 1);
    tick;
    in_valid = 1'b0;
    in_msb_first = !m;
    chk("lat_valid", out_valid, 0);
    chk("lat_busy", busy, 1);
    chk("lat_rdy", in_ready, 0);
    chk("lat_ser", serial_out, IDLE);
    tick;
    for (int i = 0; i < 8; i++) begin
      for (int c = 0; c < per; c++) begin
        chk("bit", serial_out, seq[7-i]);
        chk("valid", out_valid, 1);
        chk("first", out_first, i == 0);
        chk("last", out_last, i == 7);
        chk("busy", busy, 1);
        shift_en = (c == per - 1);
        tick;
      end
    end
    chk("end_valid", out_valid, 0);
    chk("end_ser", serial_out, IDLE);
    chk("end_busy", busy, 0);
    chk("end_rdy", in_ready, 1);
  endtask

  task automatic stream(input int n, input logic [23:0] w, input logic [2:0] m, input logic [23:0] exp);
    int sent = 0;
    int k = 0;
    int cyc = 0;
    int nb = n * 8;
    logic acc;
    in_valid = 1'b1;
    in_data = w[23 -: 8];
    in_msb_first = m[0];
    shift_en = 1'b1;
    while (k < nb && cyc < 100) begin
      if (out_valid) begin
        chk("st_bit", serial_out, exp[nb-1-k]);
        chk("st_first", out_first, (k % 8) == 0);
        chk("st_last", out_last, (k % 8) == 7);
        k++;
      end else if (k > 0) begin
        chk("st_gap", out_valid, 1);
      end
      acc = in_valid && in_ready;
      tick;
      cyc++;
      if (acc) begin
        sent++;
        chk("st_bp_rdy", in_ready, 0);
        if (sent < n) begin
          in_data = w[23-8*sent -: 8];
          in_msb_first = m[sent];
        end else in_valid = 1'b0;
      end
    end
    chk("st_len", k, nb);
    chk("st_sent", sent, n);
    tick;
    chk("st_idle_valid", out_valid, 0);
    chk("st_idle_busy", busy, 0);
  endtask

  initial begin
    logic acc;
    int idx;
    vecs[0] = '{d: 8'hB1, m: 1'b1, per: 1, seq: 8'b10110001};
    vecs[1] = '{d: 8'hB1, m: 1'b0, per: 1, seq: 8'b10001101};
    vecs[2] = '{d: 8'hC3, m: 1'b1, per: 4, seq: 8'b11000011};
    vecs[3] = '{d: 8'h0F, m: 1'b0, per: 1, seq: 8'b11110000};
    vecs[4] = '{d: 8'h96, m: 1'b0, per: 3, seq: 8'b01101001};
    reset = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_msb_first = 1'b0;
    shift_en = 1'b0;
    tick;
    tick;
    chk("rst_rdy", in_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_ser", serial_out, IDLE);
    chk("rst_busy", busy, 0);
    chk("rst_first", out_first, 0);
    chk("rst_last", out_last, 0);
    reset = 1'b0;
    #1;
    chk("rst_rdy_after", in_ready, 1);
    for (int v = 0; v < 5; v++) send_word(vecs[v].d, vecs[v].m, vecs[v].per, vecs[v].seq);
    stream(2, 24'hB10F00, 3'b001, 24'h00B1F0);
    stream(3, 24'h112233, 3'b111, 24'h112233);
    // reset mid-word with another word held
    in_valid = 1'b1;
    in_data = 8'hFF;
    in_msb_first = 1'b1;
    shift_en = 1'b1;
    tick;
    in_data = 8'hAA;
    chk("mr_rdy_full", in_ready, 0);
    tick;
    chk("mr_b1", serial_out, 1);
    chk("mr_first", out_first, 1);
    tick;
    in_valid = 1'b0;
    chk("mr_held_busy", busy, 1);
    chk("mr_held_rdy", in_ready, 0);
    tick;
    chk("mr_b3_valid", out_valid, 1);
    reset = 1'b1;
    #1;
    chk("mr_rdy_in_rst", in_ready, 0);
    tick;
    reset = 1'b0;
    #1;
    chk("mr_valid", out_valid, 0);
    chk("mr_ser", serial_out, IDLE);
    chk("mr_busy", busy, 0);
    chk("mr_rdy", in_ready, 1);
    chk("mr_last", out_last, 0);
    tick;
    chk("mr_valid2", out_valid, 0);
    chk("mr_busy2", busy, 0);
    send_word(8'h5A, 1'b1, 1, 8'b01011010);
    // randomized traffic against the word-queue model
    acc = 1'b0;
    idx = 0;
    for (int cyc = 0; cyc < 3200; cyc++) begin
      chk("rnd_busy", busy, q.size() != 0);
      if (!out_valid) chk("rnd_idle_ser", serial_out, IDLE);
      else if (q.size() == 0) chk("rnd_spurious", out_valid, 0);
      else begin
        chk("rnd_bit", serial_out, q[0].m ? q[0].d[7-idx] : q[0].d[idx]);
        chk("rnd_first", out_first, idx == 0);
        chk("rnd_last", out_last, idx == 7);
      end
      if (cyc >= 3000) begin
        in_valid = 1'b0;
        shift_en = 1'b1;
      end else begin
        if (!in_valid || acc) begin
          in_valid = 1'($urandom_range(0, 1));
          in_data = 8'($urandom);
          in_msb_first = 1'($urandom);
        end
        shift_en = ($urandom_range(0, 3) != 0);
      end
      acc = in_valid && in_ready;
      if (out_valid && shift_en && q.size() != 0) begin
        idx++;
        if (idx == 8) begin
          idx = 0;
          void'(q.pop_front());
        end
      end
      if (acc) q.push_back('{d: in_data, m: in_msb_first});
      tick;
    end
    chk("rnd_drained", q.size(), 0);
    chk("rnd_end_busy", busy, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
